// File: rtl/videogen_pkg.sv
// rtl/videogen_pkg.sv - pattern codes, latency-tester modes and colour-bar table
package videogen_pkg;

  localparam logic [2:0] PAT_LEGACY = 3'd0;
  localparam logic [2:0] PAT_BARS   = 3'd1;
  localparam logic [2:0] PAT_SOLID  = 3'd2;
  localparam logic [2:0] PAT_XHATCH = 3'd3;

  typedef enum logic [1:0] {
    LT_MODE_OFF    = 2'd0,
    LT_MODE_TL     = 2'd1,
    LT_MODE_CENTRE = 2'd2,
    LT_MODE_BR     = 2'd3
  } lt_mode_e;

  // Bar colours left to right: W,Y,C,G,M,R,B,K as {r,g,b} on/off flags
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;
      3'd1:    return 3'b110;
      3'd2:    return 3'b011;
      3'd3:    return 3'b010;
      3'd4:    return 3'b101;
      3'd5:    return 3'b100;
      3'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/videogen_if.sv
// rtl/videogen_if.sv - video output bus towards the output mux
interface videogen_if #(parameter int COLOR_W = 8);

  logic [COLOR_W-1:0] R_out;
  logic [COLOR_W-1:0] G_out;
  logic [COLOR_W-1:0] B_out;
  logic               HSYNC_out;
  logic               VSYNC_out;
  logic               ENABLE_out;
  logic               PCLK_out;

  modport master (output R_out, G_out, B_out, HSYNC_out, VSYNC_out, ENABLE_out, PCLK_out);
  modport slave  (input  R_out, G_out, B_out, HSYNC_out, VSYNC_out, ENABLE_out, PCLK_out);

endinterface

// File: rtl/videogen_timing.sv
// rtl/videogen_timing.sv - free-running h/v counters, syncs, data enable and frame tracking
module videogen_timing #(
  parameter int   H_SYNCLEN   = 62,
  parameter int   H_BACKPORCH = 60,
  parameter int   H_ACTIVE    = 720,
  parameter int   H_TOTAL     = 858,
  parameter int   V_SYNCLEN   = 6,
  parameter int   V_BACKPORCH = 30,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_TOTAL     = 525,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0
) (
  input  logic       clk27,
  input  logic       reset_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       in_active,
  output logic       frame_end,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam logic [9:0] X_START = 10'(H_SYNCLEN + H_BACKPORCH);
  localparam logic [9:0] Y_START = 10'(V_SYNCLEN + V_BACKPORCH);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;

  // Active-area coordinates; blanking wraps to large unsigned values and fails the range test
  always_comb begin
    x         = h_cnt - X_START;
    y         = v_cnt - Y_START;
    in_active = (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
    frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  end

  // Raster position counters
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Registered syncs, data enable and frame marker/counter
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      hsync       <= (h_cnt < 10'(H_SYNCLEN)) ? HS_POL : ~HS_POL;
      vsync       <= (v_cnt < 10'(V_SYNCLEN)) ? VS_POL : ~VS_POL;
      de          <= in_active;
      frame_start <= frame_end;
      if (frame_end)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/videogen_multi.sv
// rtl/videogen_multi.sv - multi-pattern test generator top; VG_SCROLL_EN animates ramp and bars
module videogen_multi
  import videogen_pkg::*;
#(
  parameter int   COLOR_W     = 8,
  parameter int   H_SYNCLEN   = 62,
  parameter int   H_BACKPORCH = 60,
  parameter int   H_ACTIVE    = 720,
  parameter int   H_TOTAL     = 858,
  parameter int   V_SYNCLEN   = 6,
  parameter int   V_BACKPORCH = 30,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_TOTAL     = 525,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0,
  parameter int   GRID_LOG2   = 5,
  parameter int   LT_W_DIV    = 4,
  parameter int   LT_H_DIV    = 4
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic [2:0]  pat_sel,
  input  logic        pat_update,
  input  logic        lt_active,
  input  logic [1:0]  lt_mode,
  videogen_if.master  vid,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam logic [COLOR_W-1:0] FULL = '1;
  localparam logic [COLOR_W-1:0] GREY = COLOR_W'(8'h50) << (COLOR_W - 8);

  // Legacy layout: 40px/16-line checker border, 512x256 ramp window centred in the active area
  localparam logic [9:0] LEG_OX  = 10'd40;
  localparam logic [9:0] LEG_OY  = 10'd16;
  localparam logic [9:0] LEG_OX1 = 10'(H_ACTIVE - 40);
  localparam logic [9:0] LEG_OY1 = 10'(V_ACTIVE - 16);
  localparam logic [9:0] LEG_CX0 = 10'((H_ACTIVE - 512) / 2);
  localparam logic [9:0] LEG_CY0 = 10'((V_ACTIVE - 256) / 2);
  localparam logic [9:0] LEG_CX1 = 10'((H_ACTIVE - 512) / 2 + 512);
  localparam logic [9:0] LEG_CY1 = 10'((V_ACTIVE - 256) / 2 + 256);

  localparam int         BAR_W  = H_ACTIVE / 8;
  localparam logic [9:0] LT_W   = 10'(H_ACTIVE / LT_W_DIV);
  localparam logic [9:0] LT_H   = 10'(V_ACTIVE / LT_H_DIV);
  localparam logic [9:0] LT_CX0 = 10'((H_ACTIVE - H_ACTIVE / LT_W_DIV) / 2);
  localparam logic [9:0] LT_CY0 = 10'((V_ACTIVE - V_ACTIVE / LT_H_DIV) / 2);
  localparam logic [9:0] LT_BX0 = 10'(H_ACTIVE - H_ACTIVE / LT_W_DIV);
  localparam logic [9:0] LT_BY0 = 10'(V_ACTIVE - V_ACTIVE / LT_H_DIV);
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  logic [9:0]         x, y;
  logic               in_active, frame_end;
  logic               hsync, vsync, de;
  logic [2:0]         pend_pat, act_pat;
  logic [2:0]         bar, bar_idx, bar_c;
  logic [COLOR_W-1:0] ramp;
  logic               leg_over, leg_ctr, xhatch, lt_box;
  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;
  lt_mode_e           lt_m;

  videogen_timing #(
    .H_SYNCLEN(H_SYNCLEN), .H_BACKPORCH(H_BACKPORCH), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .V_SYNCLEN(V_SYNCLEN), .V_BACKPORCH(V_BACKPORCH), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk27(clk27), .reset_n(reset_n), .x(x), .y(y), .in_active(in_active),
    .frame_end(frame_end), .hsync(hsync), .vsync(vsync), .de(de),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  assign vid.HSYNC_out  = hsync;
  assign vid.VSYNC_out  = vsync;
  assign vid.ENABLE_out = de;
  assign vid.PCLK_out   = clk27;
  assign lt_m           = lt_mode_e'(lt_mode);

  // Pattern request capture; new pattern only takes over at the frame boundary
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      pend_pat <= PAT_LEGACY;
      act_pat  <= PAT_LEGACY;
    end else begin
      if (pat_update)
        pend_pat <= pat_sel;
      if (frame_end)
        act_pat <= pend_pat;
    end
  end

  // Per-pattern geometry: bar index by constant thresholds, ramp, legacy regions, grid lines
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++)
      if (x >= 10'(k * BAR_W))
        bar = 3'(k);
`ifdef VG_SCROLL_EN
    bar_idx = bar + frame_cnt[5:3];
    ramp    = COLOR_W'(((x - LEG_CX0) >> 1) + 10'(frame_cnt));
`else
    bar_idx = bar;
    ramp    = COLOR_W'((x - LEG_CX0) >> 1);
`endif
    bar_c    = bar_rgb(bar_idx);
    leg_over = (x < LEG_OX) || (x >= LEG_OX1) || (y < LEG_OY) || (y >= LEG_OY1);
    leg_ctr  = (x >= LEG_CX0) && (x < LEG_CX1) && (y >= LEG_CY0) && (y < LEG_CY1);
    xhatch   = (x[GRID_LOG2-1:0] == '0) || (y[GRID_LOG2-1:0] == '0) ||
               (x == X_LAST) || (y == Y_LAST);
  end

  // Latency-tester box region for the selected corner/centre
  always_comb begin
    lt_box = 1'b0;
    case (lt_m)
      LT_MODE_TL:     lt_box = (x < LT_W) && (y < LT_H);
      LT_MODE_CENTRE: lt_box = (x >= LT_CX0) && (x < LT_CX0 + LT_W) &&
                               (y >= LT_CY0) && (y < LT_CY0 + LT_H);
      LT_MODE_BR:     lt_box = (x >= LT_BX0) && (y >= LT_BY0);
      default:        lt_box = 1'b0;
    endcase
  end

  // Pixel colour: latency tester overrides the frame-synchronous pattern
  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    if (lt_active) begin
      pix_r = lt_box ? FULL : '0;
      pix_g = pix_r;
      pix_b = pix_r;
    end else begin
      case (act_pat)
        PAT_LEGACY: begin
          if (leg_over)
            pix_r = (x[0] ^ y[0]) ? FULL : '0;
          else if (leg_ctr)
            pix_r = ramp;
          else
            pix_r = GREY;
          pix_g = pix_r;
          pix_b = pix_r;
        end
        PAT_BARS: begin
          pix_r = {COLOR_W{bar_c[2]}};
          pix_g = {COLOR_W{bar_c[1]}};
          pix_b = {COLOR_W{bar_c[0]}};
        end
        PAT_SOLID: begin
          pix_r = FULL;
          pix_g = FULL;
          pix_b = FULL;
        end
        PAT_XHATCH: begin
          pix_r = xhatch ? FULL : '0;
          pix_g = pix_r;
          pix_b = pix_r;
        end
        default: ;
      endcase
    end
  end

  // Pixel output register, blanked outside the active area so it lines up with ENABLE_out
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      vid.R_out <= '0;
      vid.G_out <= '0;
      vid.B_out <= '0;
    end else begin
      vid.R_out <= in_active ? pix_r : '0;
      vid.G_out <= in_active ? pix_g : '0;
      vid.B_out <= in_active ? pix_b : '0;
    end
  end

endmodule

// File: tb/tb_videogen_multi.sv
// tb/tb_videogen_multi.sv - self-checking bench for videogen_multi
module tb_videogen_multi;

  localparam int HT = 858;
  localparam int VT = 525;
  localparam int FR = HT * VT;
  localparam int XS = 122;
  localparam int YS = 36;

  localparam int P_U1     = (250 + YS) * HT;
  localparam int P_U3     = FR + (300 + YS) * HT;
  localparam int P_UB     = 2 * FR - 1;
  localparam int P_LT_ON  = 2 * FR + (150 + YS) * HT;
  localparam int P_LT_OFF = 2 * FR + (310 + YS) * HT;
  localparam int N_CYC    = 3 * FR + (250 + YS) * HT;

  typedef struct {
    int         p;
    int         f;
    int         x;
    int         y;
    logic [23:0] rgb;
  } probe_t;

  logic       clk27 = 1'b0;
  logic       reset_n;
  logic [2:0] pat_sel;
  logic       pat_update;
  logic       lt_active;
  logic [1:0] lt_mode;
  logic       frame_start;
  logic [7:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  probe_t sb[$];

  videogen_if #(.COLOR_W(8)) vid ();

  videogen_multi dut (
    .clk27(clk27), .reset_n(reset_n), .pat_sel(pat_sel), .pat_update(pat_update),
    .lt_active(lt_active), .lt_mode(lt_mode), .vid(vid),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 clk27 = ~clk27;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic sb_push(input int f, input int x, input int y, input logic [23:0] rgb);
    probe_t pr;
    int i;
    pr.p = f * FR + (y + YS) * HT + x + XS;
    pr.f = f;
    pr.x = x;
    pr.y = y;
    pr.rgb = rgb;
    i = 0;
    while (i < sb.size() && sb[i].p < pr.p)
      i++;
    sb.insert(i, pr);
  endtask

  initial begin
    int h, v, f;
    int hs_bad, vs_bad, de_bad, blank_bad, fs_bad, fc_bad;
    int en0, hs0, vs0, first_fs;
    logic de_exp, last;
    logic [23:0] pix;
    probe_t pr;

    h = 0; v = 0; f = 0;
    hs_bad = 0; vs_bad = 0; de_bad = 0; blank_bad = 0; fs_bad = 0; fc_bad = 0;
    en0 = 0; hs0 = 0; vs0 = 0; first_fs = -1;

    reset_n = 1'b0;
    pat_sel = 3'd0;
    pat_update = 1'b0;
    lt_active = 1'b0;
    lt_mode = 2'd0;
    repeat (4) @(posedge clk27);
    #1;
    check_eq("rst_rgb", {8'h0, vid.R_out, vid.G_out, vid.B_out}, 32'h0);
    check_eq("rst_hsync", vid.HSYNC_out, 0);
    check_eq("rst_vsync", vid.VSYNC_out, 0);
    check_eq("rst_enable", vid.ENABLE_out, 0);
    check_eq("rst_frame_start", frame_start, 0);
    check_eq("rst_frame_cnt", frame_cnt, 0);
    check_eq("pclk_follows_clk", vid.PCLK_out, clk27);
    @(negedge clk27);
    reset_n = 1'b1;

    // frame 0, legacy pattern
    sb_push(0, 0, 0, 24'h000000);
    sb_push(0, 1, 0, 24'hffffff);
    sb_push(0, 41, 20, 24'h505050);
    sb_push(0, 104, 200, 24'h000000);
    sb_push(0, 300, 200, 24'h626262);
    sb_push(0, 615, 367, 24'hffffff);
    sb_push(0, 616, 200, 24'h505050);

    for (int cyc = 1; cyc <= N_CYC; cyc++) begin
      @(posedge clk27);
      #1;
      pix = {vid.R_out, vid.G_out, vid.B_out};
      if (vid.HSYNC_out !== (h >= 62)) hs_bad++;
      if (vid.VSYNC_out !== (v >= 6)) vs_bad++;
      de_exp = (h >= XS) && (h < XS + 720) && (v >= YS) && (v < YS + 480);
      if (vid.ENABLE_out !== de_exp) de_bad++;
      if (!vid.ENABLE_out && pix != 24'h0) blank_bad++;
      last = (h == HT - 1) && (v == VT - 1);
      if (frame_start !== last) fs_bad++;
      if (frame_start === 1'b1 && first_fs < 0) first_fs = cyc;
      if (frame_cnt !== 8'(f + (last ? 1 : 0))) fc_bad++;
      if (f == 0) begin
        if (vid.ENABLE_out) en0++;
        if (!vid.HSYNC_out) hs0++;
        if (!vid.VSYNC_out) vs0++;
      end
      while (sb.size() > 0 && sb[0].p == cyc - 1) begin
        pr = sb.pop_front();
        check_eq($sformatf("pix_f%0d_x%0d_y%0d", pr.f, pr.x, pr.y), {8'h0, pix}, {8'h0, pr.rgb});
      end

      h++;
      if (h == HT) begin
        h = 0;
        v++;
        if (v == VT) begin
          v = 0;
          f++;
        end
      end

      pat_update = 1'b0;
      if (cyc == P_U1) begin
        pat_sel = 3'd1;
        pat_update = 1'b1;
        sb_push(0, 300, 300, 24'h626262);
        sb_push(0, 679, 463, 24'h505050);
        sb_push(0, 680, 463, 24'hffffff);
        sb_push(0, 21, 470, 24'hffffff);
        sb_push(1, 0, 100, 24'hffffff);
        sb_push(1, 45, 100, 24'hffffff);
        sb_push(1, 89, 100, 24'hffffff);
        sb_push(1, 90, 100, 24'hffff00);
        sb_push(1, 179, 100, 24'hffff00);
        sb_push(1, 180, 100, 24'h00ffff);
        sb_push(1, 270, 100, 24'h00ff00);
        sb_push(1, 360, 100, 24'hff00ff);
        sb_push(1, 450, 100, 24'hff0000);
        sb_push(1, 540, 100, 24'h0000ff);
        sb_push(1, 630, 100, 24'h000000);
        sb_push(1, 675, 100, 24'h000000);
        sb_push(1, 719, 100, 24'h000000);
      end
      if (cyc == P_U3) begin
        pat_sel = 3'd3;
        pat_update = 1'b1;
        sb_push(1, 45, 400, 24'hffffff);
        sb_push(2, 0, 1, 24'hffffff);
        sb_push(2, 32, 5, 24'hffffff);
        sb_push(2, 33, 5, 24'h000000);
        sb_push(2, 33, 64, 24'hffffff);
        sb_push(2, 33, 65, 24'h000000);
        sb_push(2, 719, 100, 24'hffffff);
        sb_push(2, 64, 330, 24'hffffff);
        sb_push(2, 65, 330, 24'h000000);
        sb_push(2, 33, 479, 24'hffffff);
      end
      if (cyc == P_UB) begin
        pat_sel = 3'd0;
        pat_update = 1'b1;
        sb_push(3, 1, 0, 24'hffffff);
`ifdef VG_SCROLL_EN
        sb_push(3, 104, 200, 24'h030303);
        sb_push(3, 300, 200, 24'h656565);
`else
        sb_push(3, 104, 200, 24'h000000);
        sb_push(3, 300, 200, 24'h626262);
`endif
      end
      if (cyc == P_LT_ON) begin
        lt_active = 1'b1;
        lt_mode = 2'd2;
        sb_push(2, 320, 160, 24'h000000);
        sb_push(2, 300, 179, 24'h000000);
        sb_push(2, 270, 180, 24'hffffff);
        sb_push(2, 269, 200, 24'h000000);
        sb_push(2, 450, 200, 24'h000000);
        sb_push(2, 64, 250, 24'h000000);
        sb_push(2, 449, 299, 24'hffffff);
        sb_push(2, 300, 300, 24'h000000);
      end
      if (cyc == P_LT_OFF) begin
        lt_active = 1'b0;
        lt_mode = 2'd0;
      end
    end

    check_eq("first_frame_start_clk", first_fs, FR);
    check_eq("f0_enable_clks", en0, 720 * 480);
    check_eq("f0_hsync_low_clks", hs0, 62 * VT);
    check_eq("f0_vsync_low_clks", vs0, 6 * HT);
    check_eq("hsync_bad_clks", hs_bad, 0);
    check_eq("vsync_bad_clks", vs_bad, 0);
    check_eq("enable_bad_clks", de_bad, 0);
    check_eq("rgb_in_blank_clks", blank_bad, 0);
    check_eq("frame_start_bad_clks", fs_bad, 0);
    check_eq("frame_cnt_bad_clks", fc_bad, 0);
    check_eq("frame_cnt_f3", frame_cnt, 3);
    check_eq("sb_unmatched", sb.size(), 0);

    reset_n = 1'b0;
    #1;
    check_eq("midrst_frame_cnt", frame_cnt, 0);
    check_eq("midrst_enable", vid.ENABLE_out, 0);
    check_eq("midrst_rgb", {8'h0, vid.R_out, vid.G_out, vid.B_out}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
